// File: rtl/seq_restoring_divider_if.sv
// Host <-> divider handshake and operand/result bundle.
//   master : host side   (drives start, dividend, divisor; observes results)
//   slave  : divider side (observes request; drives busy, done, quotient,
//            remainder, div_by_zero)
interface seq_restoring_divider_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider: one quotient bit per clock.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active-high
//   bus  - slave modport of seq_restoring_divider_if:
//          start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out
// Latency: done pulses in the cycle after the (WIDTH+1)th edge counting the
// accepting edge; a zero divisor finishes right after the accepting edge.
// Build option: define DIV_SIGNED_EN for two's complement operands (magnitudes
// feed the unsigned core, signs are re-applied when the result is latched).
module seq_restoring_divider #(
   parameter int unsigned WIDTH = 8
) (
   input logic                   clk,
   input logic                   rst,
   seq_restoring_divider_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    count, count_nx;
   logic [WIDTH-1:0] r, r_nx;          // partial remainder
   logic [WIDTH-1:0] q, q_nx;          // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] dvs, dvs_nx;      // captured divisor (magnitude)
   logic [WIDTH-1:0] quot, quot_nx;
   logic [WIDTH-1:0] rem, rem_nx;
   logic             dz, dz_nx;
   logic             busy, busy_nx;
   logic             done, done_nx;

   logic             accept_c;
   logic [WIDTH-1:0] dvd_mag_c, dvs_mag_c;
   logic [WIDTH-1:0] q_fin_c, r_fin_c;
   logic [WIDTH:0]   r_sh_c, dvs_inv_c;
   logic [WIDTH-1:0] diff_c;
   logic             carry_c;
   logic             no_borrow_c;
   logic [WIDTH-1:0] r_it_c, q_it_c;

   assign accept_c = (state != RUN) && bus.start;

   // One iteration: shift {R,Q} left, then R - D on a WIDTH+1-bit ripple of
   // full adders (D inverted, carry-in 1). Carry-out set means no borrow.
   always_comb begin
      r_sh_c    = {r, q[WIDTH-1]};
      dvs_inv_c = ~{1'b0, dvs};
      diff_c    = '0;
      carry_c   = 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) begin
         diff_c[i] = r_sh_c[i] ^ dvs_inv_c[i] ^ carry_c;
         carry_c   = (r_sh_c[i] & dvs_inv_c[i]) | (carry_c & (r_sh_c[i] ^ dvs_inv_c[i]));
      end
      // top cell: only its carry matters, the sum bit is zero whenever it is kept
      no_borrow_c = (r_sh_c[WIDTH] & dvs_inv_c[WIDTH]) |
                    (carry_c & (r_sh_c[WIDTH] ^ dvs_inv_c[WIDTH]));
      r_it_c = no_borrow_c ? diff_c : r_sh_c[WIDTH-1:0];
      q_it_c = {q[WIDTH-2:0], no_borrow_c};
   end

`ifdef DIV_SIGNED_EN
   logic sgn_q, sgn_r;

   assign dvd_mag_c = bus.dividend[WIDTH-1] ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
   assign dvs_mag_c = bus.divisor[WIDTH-1]  ? (~bus.divisor + WIDTH'(1))  : bus.divisor;
   // most-negative / -1 wraps back to most-negative through this negation
   assign q_fin_c   = sgn_q ? (~q_it_c + WIDTH'(1)) : q_it_c;
   assign r_fin_c   = sgn_r ? (~r_it_c + WIDTH'(1)) : r_it_c;

   // Result signs: quotient from operand sign mismatch, remainder follows dividend.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sgn_q <= 1'b0;
         sgn_r <= 1'b0;
      end else if (accept_c) begin
         sgn_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
         sgn_r <= bus.dividend[WIDTH-1];
      end
   end
`else
   assign dvd_mag_c = bus.dividend;
   assign dvs_mag_c = bus.divisor;
   assign q_fin_c   = q_it_c;
   assign r_fin_c   = r_it_c;
`endif

   // Next-state and datapath next values.
   always_comb begin
      state_nx = state;
      count_nx = count;
      r_nx     = r;
      q_nx     = q;
      dvs_nx   = dvs;
      quot_nx  = quot;
      rem_nx   = rem;
      dz_nx    = dz;
      unique case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               r_nx   = '0;
               q_nx   = dvd_mag_c;
               dvs_nx = dvs_mag_c;
               dz_nx  = 1'b0;
               if (bus.divisor == '0) begin
                  state_nx = DONE;
                  count_nx = '0;
                  quot_nx  = '1;
                  rem_nx   = bus.dividend;
                  dz_nx    = 1'b1;
               end else begin
                  state_nx = RUN;
                  count_nx = CW'(WIDTH);
               end
            end else begin
               state_nx = IDLE;
            end
         end
         RUN: begin
            r_nx     = r_it_c;
            q_nx     = q_it_c;
            count_nx = count - CW'(1);
            if (count == CW'(1)) begin
               state_nx = DONE;
               quot_nx  = q_fin_c;
               rem_nx   = r_fin_c;
            end
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx == RUN);
      done_nx = (state_nx == DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         r     <= '0;
         q     <= '0;
         dvs   <= '0;
         quot  <= '0;
         rem   <= '0;
         dz    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         r     <= r_nx;
         q     <= q_nx;
         dvs   <= dvs_nx;
         quot  <= quot_nx;
         rem   <= rem_nx;
         dz    <= dz_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.quotient    = quot;
   assign bus.remainder   = rem;
   assign bus.div_by_zero = dz;
endmodule
